// File: rtl/saes_pkg.sv
// Shared S-AES definitions: S-box, nibble/row permutations, round constants and FSM states.
package saes_pkg;

  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;

  typedef enum logic [2:0] {
    StIdle,
    StKey1,
    StKey2,
    StRnd1,
    StRnd2
  } saes_state_e;

  function automatic logic [3:0] sub_nib(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h9;
      4'h1: r = 4'h4;
      4'h2: r = 4'hA;
      4'h3: r = 4'hB;
      4'h4: r = 4'hD;
      4'h5: r = 4'h1;
      4'h6: r = 4'h8;
      4'h7: r = 4'h5;
      4'h8: r = 4'h6;
      4'h9: r = 4'h2;
      4'hA: r = 4'h0;
      4'hB: r = 4'h3;
      4'hC: r = 4'hC;
      4'hD: r = 4'hE;
      4'hE: r = 4'hF;
      default: r = 4'h7;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sub_word(input logic [15:0] s);
    return {sub_nib(s[15:12]), sub_nib(s[11:8]), sub_nib(s[7:4]), sub_nib(s[3:0])};
  endfunction

  function automatic logic [7:0] rot_nib(input logic [7:0] w);
    return {w[3:0], w[7:4]};
  endfunction

  // Second state row lives in nibbles [11:8] and [3:0]; rotating a 2-wide row is a swap.
  function automatic logic [15:0] shift_row(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

endpackage

// File: rtl/saes_keyexp_step.sv
// One S-AES key expansion step: derives the next two key words from the previous two.
module saes_keyexp_step
  import saes_pkg::*;
(
  input  logic [7:0] wa_i,
  input  logic [7:0] wb_i,
  input  logic [7:0] rcon_i,
  output logic [7:0] wc_o,
  output logic [7:0] wd_o
);

  logic [7:0] rot;
  logic [7:0] g;

  // g(wb, rcon) = rcon ^ SubNib(RotNib(wb)), then chain the XORs.
  always_comb begin
    rot  = rot_nib(wb_i);
    g    = rcon_i ^ {sub_nib(rot[7:4]), sub_nib(rot[3:0])};
    wc_o = wa_i ^ g;
    wd_o = wc_o ^ wb_i;
  end

endmodule

// File: rtl/saes_ctrl.sv
// Iterative S-AES encryption sequencer: expands the key one round key per cycle, drives the
// external full-round datapath, then performs the final (no MixColumns) round locally.
// Optional build macro SAES_KEY_CACHE_EN keeps the last expanded key so a repeated key skips
// the two expansion cycles.
module saes_ctrl
  import saes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic [15:0] key_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] data_out,
  output logic [15:0] rnd_in,
  output logic [15:0] rnd_key,
  input  logic [15:0] rnd_out
);

  saes_state_e state_q, state_d;
  logic [15:0] st_q, st_d;
  logic [15:0] k0_q, k0_d;
  logic [15:0] k1_q, k1_d;
  logic [15:0] k2_q, k2_d;
  logic [15:0] dout_q, dout_d;
  logic        done_q, done_d;

  logic [7:0] ks_wa, ks_wb, ks_rcon, ks_wc, ks_wd;

`ifdef SAES_KEY_CACHE_EN
  logic [15:0] c_k0_q, c_k1_q, c_k2_q;
  logic        c_vld_q;
`endif

  // Share one expansion step: KEY2 works on K1, every other state on K0.
  always_comb begin
    if (state_q == StKey2) begin
      ks_wa   = k1_q[15:8];
      ks_wb   = k1_q[7:0];
      ks_rcon = RCON2;
    end else begin
      ks_wa   = k0_q[15:8];
      ks_wb   = k0_q[7:0];
      ks_rcon = RCON1;
    end
  end

  saes_keyexp_step u_keyexp_step (
    .wa_i   (ks_wa),
    .wb_i   (ks_wb),
    .rcon_i (ks_rcon),
    .wc_o   (ks_wc),
    .wd_o   (ks_wd)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          k0_d    = key_in;
          st_d    = data_in ^ key_in;
          state_d = StKey1;
`ifdef SAES_KEY_CACHE_EN
          if (c_vld_q && (key_in == c_k0_q)) begin
            k1_d    = c_k1_q;
            k2_d    = c_k2_q;
            state_d = StRnd1;
          end
`endif
        end
      end
      StKey1: begin
        k1_d    = {ks_wc, ks_wd};
        state_d = StKey2;
      end
      StKey2: begin
        k2_d    = {ks_wc, ks_wd};
        state_d = StRnd1;
      end
      StRnd1: begin
        st_d    = rnd_out;
        state_d = StRnd2;
      end
      StRnd2: begin
        dout_d  = shift_row(sub_word(st_q)) ^ k2_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      st_q    <= '0;
      k0_q    <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

`ifdef SAES_KEY_CACHE_EN
  // Cache is only written once a full expansion completes, so an abort leaves it invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_k0_q  <= '0;
      c_k1_q  <= '0;
      c_k2_q  <= '0;
      c_vld_q <= 1'b0;
    end else if (state_q == StKey2) begin
      c_k0_q  <= k0_q;
      c_k1_q  <= k1_q;
      c_k2_q  <= {ks_wc, ks_wd};
      c_vld_q <= 1'b1;
    end
  end
`endif

  // Outputs; the datapath port pair only matters in RND1.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = done_q;
    data_out = dout_q;
    rnd_in   = st_q;
    rnd_key  = k1_q;
  end

endmodule
